// File: rtl/operand_fetch_pkg.sv
// Shared RISC-V execute-stage definitions: datapath sizes, ALU opcodes and
// the operand packet handed from operand fetch to the ALU.
package riscv_definitions;

  localparam int XLEN    = 32;
  localparam int NREGS   = 32;
  localparam int RADDR_W = $clog2(NREGS);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ops_t;

  typedef struct packed {
    logic [XLEN-1:0]    operand_a;
    logic [XLEN-1:0]    operand_b;
    alu_ops_t           alu_op;
    logic [RADDR_W-1:0] rd;
  } issue_pkt_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-to-ALU issue bus: the decode request side and the ALU packet side,
// each with its own valid/ready handshake.
interface operand_fetch_if;
  import riscv_definitions::*;

  logic               in_valid;
  logic               in_ready;
  logic [RADDR_W-1:0] in_rs1;
  logic [RADDR_W-1:0] in_rs2;
  logic [RADDR_W-1:0] in_rd;
  logic [XLEN-1:0]    in_imm;
  logic               in_use_imm;
  alu_ops_t           in_alu_op;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    operand_a;
  logic [XLEN-1:0]    operand_b;
  alu_ops_t           alu_op;
  logic [RADDR_W-1:0] out_rd;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_imm, in_use_imm, in_alu_op, out_ready,
    input  in_ready, out_valid, operand_a, operand_b, alu_op, out_rd
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_imm, in_use_imm, in_alu_op, out_ready,
    output in_ready, out_valid, operand_a, operand_b, alu_op, out_rd
  );

endinterface

// File: rtl/operand_fetch_reg_file.sv
// Integer register file: two asynchronous read ports, one synchronous write
// port, x0 reads as zero, whole array cleared by the async active-low reset.
module reg_file
  import riscv_definitions::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [RADDR_W-1:0] raddr_a,
  output logic [XLEN-1:0]    rdata_a,
  input  logic [RADDR_W-1:0] raddr_b,
  output logic [XLEN-1:0]    rdata_b,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]    wdata
);

  logic [XLEN-1:0] rf [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (we && (waddr != '0)) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : rf[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : rf[raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// Execute-stage operand issue: register read with same-cycle writeback bypass,
// immediate select, and a two-entry skid buffer toward the ALU.
//
// state    | meaning
// ST_EMPTY | no packet held, out_valid low
// ST_ONE   | main reg holds the packet on the outputs
// ST_TWO   | main and skid both full, in_ready low
module operand_fetch
  import riscv_definitions::*;
(
  input  logic               clk,
  input  logic               reset,
  operand_fetch_if.slave     iss,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  buf_state_t      state_q;
  issue_pkt_t      main_q;
  issue_pkt_t      skid_q;
  issue_pkt_t      new_pkt;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            accept;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;

  reg_file u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (iss.in_rs1),
    .rdata_a (rf_a),
    .raddr_b (iss.in_rs2),
    .rdata_b (rf_b),
    .we      (wb_en),
    .waddr   (wb_rd),
    .wdata   (wb_data)
  );

  // A writeback landing this cycle is not yet in the array, so forward it.
  function automatic logic [XLEN-1:0] read_src(
    input logic [RADDR_W-1:0] rs,
    input logic [XLEN-1:0]    rf_val
  );
    if (rs == '0)                 return '0;
    else if (wb_en && wb_rd == rs) return wb_data;
    else                          return rf_val;
  endfunction

  assign src_a  = read_src(iss.in_rs1, rf_a);
  assign src_b  = read_src(iss.in_rs2, rf_b);
  assign accept = iss.in_valid && in_ready_q;

  always_comb begin
    new_pkt           = '0;
    new_pkt.operand_a = src_a;
    new_pkt.operand_b = iss.in_use_imm ? iss.in_imm : src_b;
    new_pkt.alu_op    = iss.in_alu_op;
    new_pkt.rd        = iss.in_rd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_q      <= new_pkt;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !iss.out_ready) begin
            skid_q     <= new_pkt;
            state_q    <= ST_TWO;
            in_ready_q <= 1'b0;
          end else if (accept && iss.out_ready) begin
            main_q <= new_pkt;
          end else if (iss.out_ready) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_TWO: begin
          if (iss.out_ready) begin
            main_q     <= skid_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign iss.in_ready  = in_ready_q;
  assign iss.out_valid = out_valid_q;
  assign iss.operand_a = main_q.operand_a;
  assign iss.operand_b = main_q.operand_b;
  assign iss.alu_op    = main_q.alu_op;
  assign iss.out_rd    = main_q.rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a vector table for single-cycle issue
// behaviour plus hand sequences for backpressure, frozen operands and reset.
module tb_operand_fetch;
  import riscv_definitions::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  operand_fetch_if ifc ();

  operand_fetch dut (
    .clk     (clk),
    .reset   (reset),
    .iss     (ifc.slave),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        in_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    alu_ops_t    op;
    logic        out_ready;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(
    input logic w, input logic [4:0] wr, input logic [31:0] wd,
    input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
    input logic [31:0] im, input logic ui, input alu_ops_t o, input logic ordy,
    input logic ev, input logic er, input logic [31:0] ea, input logic [31:0] eb
  );
    vec_t t;
    t.wb_en = w; t.wb_rd = wr; t.wb_data = wd;
    t.in_valid = v; t.rs1 = r1; t.rs2 = r2; t.rd = d;
    t.imm = im; t.use_imm = ui; t.op = o; t.out_ready = ordy;
    t.exp_valid = ev; t.exp_ready = er; t.exp_a = ea; t.exp_b = eb;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic w, input logic [4:0] r, input logic [31:0] d);
    wb_en = w; wb_rd = r; wb_data = d;
  endtask

  task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input logic [31:0] im, input logic ui,
                        input alu_ops_t o);
    ifc.in_valid = v; ifc.in_rs1 = r1; ifc.in_rs2 = r2; ifc.in_rd = d;
    ifc.in_imm = im; ifc.in_use_imm = ui; ifc.in_alu_op = o;
  endtask

  task automatic chk_pkt(input string name, input logic [31:0] a, input logic [31:0] b,
                         input alu_ops_t o, input logic [4:0] d);
    chk({name, ".valid"}, 32'(ifc.out_valid), 32'd1);
    chk({name, ".a"}, ifc.operand_a, a);
    chk({name, ".b"}, ifc.operand_b, b);
    chk({name, ".op"}, 32'(ifc.alu_op), 32'(o));
    chk({name, ".rd"}, 32'(ifc.out_rd), 32'(d));
  endtask

  initial begin
    reset = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, ALU_ADD);
    ifc.out_ready = 1'b0;

    vecs[0] = mk(1, 5'd5, 32'h0000_0010, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, ALU_ADD, 1, 0, 1, 32'd0, 32'd0);
    vecs[1] = mk(1, 5'd6, 32'h0000_0003, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, ALU_ADD, 1, 0, 1, 32'd0, 32'd0);
    vecs[2] = mk(0, 5'd0, 32'd0, 1, 5'd5, 5'd6, 5'd1, 32'd0, 0, ALU_ADD, 1, 1, 1, 32'h10, 32'h3);
    vecs[3] = mk(1, 5'd7, 32'hDEAD_BEEF, 1, 5'd7, 5'd5, 5'd2, 32'd0, 0, ALU_SUB, 1, 1, 1, 32'hDEAD_BEEF, 32'h10);
    vecs[4] = mk(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 5'd0, 5'd3, 32'd0, 0, ALU_AND, 1, 1, 1, 32'd0, 32'd0);
    vecs[5] = mk(0, 5'd0, 32'd0, 1, 5'd6, 5'd5, 5'd4, 32'hFFFF_FFFC, 1, ALU_OR, 1, 1, 1, 32'h3, 32'hFFFF_FFFC);
    vecs[6] = mk(0, 5'd0, 32'd0, 1, 5'd7, 5'd6, 5'd5, 32'd0, 0, ALU_XOR, 1, 1, 1, 32'hDEAD_BEEF, 32'h3);
    vecs[7] = mk(0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, ALU_ADD, 1, 0, 1, 32'd0, 32'd0);

    #12;
    chk("rst.out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst.in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst.operand_a", ifc.operand_a, 32'd0);
    chk("rst.operand_b", ifc.operand_b, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      set_wb(vecs[i].wb_en, vecs[i].wb_rd, vecs[i].wb_data);
      set_in(vecs[i].in_valid, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
             vecs[i].imm, vecs[i].use_imm, vecs[i].op);
      ifc.out_ready = vecs[i].out_ready;
      tick();
      chk($sformatf("vec%0d.in_ready", i), 32'(ifc.in_ready), 32'(vecs[i].exp_ready));
      if (vecs[i].exp_valid)
        chk_pkt($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].op, vecs[i].rd);
      else
        chk($sformatf("vec%0d.valid", i), 32'(ifc.out_valid), 32'd0);
    end

    // Backpressure: P1, P2 fill the buffer, P3 stalls, then drain in order.
    set_wb(1'b0, 5'd0, 32'd0);
    ifc.out_ready = 1'b0;
    set_in(1'b1, 5'd5, 5'd0, 5'd10, 32'd0, 1'b0, ALU_ADD);
    tick();
    chk("bp.p1_ready", 32'(ifc.in_ready), 32'd1);
    chk_pkt("bp.p1", 32'h10, 32'd0, ALU_ADD, 5'd10);
    set_in(1'b1, 5'd6, 5'd0, 5'd11, 32'd0, 1'b0, ALU_SUB);
    tick();
    chk("bp.full_ready", 32'(ifc.in_ready), 32'd0);
    chk_pkt("bp.hold_p1", 32'h10, 32'd0, ALU_ADD, 5'd10);
    set_in(1'b1, 5'd7, 5'd0, 5'd12, 32'd0, 1'b0, ALU_XOR);
    tick();
    chk("bp.stall_ready", 32'(ifc.in_ready), 32'd0);
    chk_pkt("bp.stall_p1", 32'h10, 32'd0, ALU_ADD, 5'd10);
    ifc.out_ready = 1'b1;
    tick();
    chk("bp.pop1_ready", 32'(ifc.in_ready), 32'd1);
    chk_pkt("bp.p2", 32'h3, 32'd0, ALU_SUB, 5'd11);
    tick();
    chk_pkt("bp.p3", 32'hDEAD_BEEF, 32'd0, ALU_XOR, 5'd12);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, ALU_ADD);
    tick();
    chk("bp.drained", 32'(ifc.out_valid), 32'd0);

    // Frozen operands: a writeback to x5 must not touch a held packet.
    ifc.out_ready = 1'b0;
    set_in(1'b1, 5'd5, 5'd6, 5'd13, 32'd0, 1'b0, ALU_SLL);
    tick();
    chk_pkt("frz.p1", 32'h10, 32'h3, ALU_SLL, 5'd13);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, ALU_ADD);
    set_wb(1'b1, 5'd5, 32'h99);
    tick();
    chk_pkt("frz.hold", 32'h10, 32'h3, ALU_SLL, 5'd13);
    set_wb(1'b0, 5'd0, 32'd0);
    ifc.out_ready = 1'b1;
    set_in(1'b1, 5'd5, 5'd0, 5'd14, 32'd0, 1'b0, ALU_SRL);
    tick();
    chk_pkt("frz.new", 32'h99, 32'd0, ALU_SRL, 5'd14);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, ALU_ADD);
    tick();
    chk("frz.drained", 32'(ifc.out_valid), 32'd0);

    // Reset with two packets buffered clears outputs immediately and the RF.
    ifc.out_ready = 1'b0;
    set_in(1'b1, 5'd5, 5'd0, 5'd15, 32'd0, 1'b0, ALU_ADD);
    tick();
    set_in(1'b1, 5'd6, 5'd0, 5'd16, 32'd0, 1'b0, ALU_ADD);
    tick();
    chk("mrst.full", 32'(ifc.in_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mrst.out_valid", 32'(ifc.out_valid), 32'd0);
    chk("mrst.in_ready", 32'(ifc.in_ready), 32'd1);
    chk("mrst.operand_a", ifc.operand_a, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b1;
    set_in(1'b1, 5'd5, 5'd6, 5'd17, 32'd0, 1'b0, ALU_SLT);
    tick();
    chk_pkt("mrst.read_x5", 32'd0, 32'd0, ALU_SLT, 5'd17);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, ALU_ADD);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
